vga_display_adapter: RTL

//   Scan-out stage downstream of the frame buffer's read port.

---
 rtl/vga_display_adapter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/vga_display_adapter.sv
// VGA scan-out: 640x480@60 timing, 2x2-doubled frame-buffer addressing, 16-colour palette.
// Counter state reaches the pins three gpu_clk later, with colour and sync kept in step.
module vga_display_adapter #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        gpu_clk,
  input  logic        gpu_rst_n,
  output logic [16:0] vga_pixel_addr,
  input  logic [3:0]  vga_pixel_data,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_vblank,
  output logic        vga_frame_start
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned FB_WIDTH = H_ACTIVE >> 1;
  localparam int unsigned H_W      = $clog2(H_TOTAL);
  localparam int unsigned V_W      = $clog2(V_TOTAL);
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned ADDR_W   = 17;

  logic [DIV_W-1:0]  div;
  logic [H_W-1:0]    h_cnt;
  logic [V_W-1:0]    v_cnt;
  logic              pix_ce;
  logic              h_last;
  logic              v_last;

  logic              active_c;
  logic              hs_c;
  logic              vs_c;
  logic [ADDR_W-1:0] v_half;
  logic [ADDR_W-1:0] h_half;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] addr_c;
  logic [11:0]       rgb_c;

  logic              active_s1, hs_s1, vs_s1;
  logic              active_s2, hs_s2, vs_s2;

  assign pix_ce = (div == DIV_W'(CLK_DIV - 1));
  assign h_last = (h_cnt == H_W'(H_TOTAL - 1));
  assign v_last = (v_cnt == V_W'(V_TOTAL - 1));

  // Pixel-rate divider and raster counters
  always_ff @(posedge gpu_clk or negedge gpu_rst_n) begin
    if (!gpu_rst_n) begin
      div             <= '0;
      h_cnt           <= '0;
      v_cnt           <= '0;
      vga_frame_start <= 1'b0;
    end else begin
      vga_frame_start <= pix_ce && h_last && v_last;
      if (pix_ce) begin
        div <= '0;
        if (h_last) begin
          h_cnt <= '0;
          v_cnt <= v_last ? '0 : v_cnt + V_W'(1);
        end else begin
          h_cnt <= h_cnt + H_W'(1);
        end
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  assign vga_vblank = (v_cnt >= V_W'(V_ACTIVE));

  assign active_c = (h_cnt < H_W'(H_ACTIVE)) && (v_cnt < V_W'(V_ACTIVE));
  assign hs_c = !((h_cnt >= H_W'(H_ACTIVE + H_FP)) &&
                  (h_cnt <= H_W'(H_ACTIVE + H_FP + H_SYNC - 1)));
  assign vs_c = !((v_cnt >= V_W'(V_ACTIVE + V_FP)) &&
                  (v_cnt <= V_W'(V_ACTIVE + V_FP + V_SYNC - 1)));

  assign v_half = ADDR_W'(v_cnt >> 1);
  assign h_half = ADDR_W'(h_cnt >> 1);

  // Row base: 320 = 256 + 64, so the full-size raster needs only two shifts and an add
  always_comb begin
    row_base = '0;
    if (FB_WIDTH == 320) begin
      row_base = (v_half << 8) + (v_half << 6);
    end else begin
      row_base = v_half * ADDR_W'(FB_WIDTH);
    end
  end

  assign addr_c = active_c ? (row_base + h_half) : '0;

  // Fixed IRGB palette: intensity lifts both the on level (A->F) and the off level (0->5)
  function automatic logic [3:0] pal_chan(input logic on, input logic intense);
    if (on) return intense ? 4'hF : 4'hA;
    else    return intense ? 4'h5 : 4'h0;
  endfunction

  assign rgb_c = {pal_chan(vga_pixel_data[2], vga_pixel_data[3]),
                  pal_chan(vga_pixel_data[1], vga_pixel_data[3]),
                  pal_chan(vga_pixel_data[0], vga_pixel_data[3])};

  // Stage 1 issues the address; stage 2 waits out the frame-buffer read; stage 3 drives pins
  always_ff @(posedge gpu_clk or negedge gpu_rst_n) begin
    if (!gpu_rst_n) begin
      vga_pixel_addr <= '0;
      active_s1      <= 1'b0;
      hs_s1          <= 1'b1;
      vs_s1          <= 1'b1;
      active_s2      <= 1'b0;
      hs_s2          <= 1'b1;
      vs_s2          <= 1'b1;
      vga_hsync      <= 1'b1;
      vga_vsync      <= 1'b1;
      vga_r          <= '0;
      vga_g          <= '0;
      vga_b          <= '0;
    end else begin
      vga_pixel_addr <= addr_c;
      active_s1      <= active_c;
      hs_s1          <= hs_c;
      vs_s1          <= vs_c;
      active_s2      <= active_s1;
      hs_s2          <= hs_s1;
      vs_s2          <= vs_s1;
      vga_hsync      <= hs_s2;
      vga_vsync      <= vs_s2;
      {vga_r, vga_g, vga_b} <= active_s2 ? rgb_c : 12'h000;
    end
  end

endmodule
